// File: rtl/alien_march_controller.sv
// Alien formation march controller: paces horizontal steps from frame ticks,
// descends and reverses at screen edges, and flags invasion or a cleared wave.
module alien_march_controller #(
  parameter int unsigned NUM_ROWS         = 3,
  parameter int unsigned NUM_COLS         = 5,
  parameter int unsigned ALIEN_SPACING_X  = 64,
  parameter int unsigned ALIEN_SPACING_Y  = 32,
  parameter int unsigned ALIEN_WIDTH      = 32,
  parameter int unsigned ALIEN_HEIGHT     = 24,
  parameter int unsigned START_X          = 100,
  parameter int unsigned START_Y          = 50,
  parameter int unsigned SCREEN_LEFT      = 8,
  parameter int unsigned SCREEN_RIGHT     = 632,
  parameter int unsigned STEP_X           = 4,
  parameter int unsigned STEP_Y           = 16,
  parameter int unsigned MIN_PERIOD       = 2,
  parameter int unsigned PERIOD_PER_ALIEN = 2,
  parameter int unsigned INVADE_Y         = 400
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         frame_tick,
  input  logic                         enable,
  input  logic                         restart,
  input  logic [NUM_ROWS*NUM_COLS-1:0] alive_matrix,
  output logic [15:0]                  origin_x,
  output logic [15:0]                  origin_y,
  output logic                         direction,
  output logic                         step_pulse,
  output logic                         descend_pulse,
  output logic [7:0]                   period,
  output logic                         invaded,
  output logic                         cleared
);

  localparam int unsigned NUM_ALIENS = NUM_ROWS * NUM_COLS;
  localparam int unsigned CNT_W      = $clog2(NUM_ALIENS + 1);

  typedef enum logic [2:0] {
    S_WAIT,
    S_EVAL,
    S_MARCH,
    S_DESCEND,
    S_HALT
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0] alive_count, pop;
  logic [7:0]       period_next;
  logic [7:0]       frame_cnt, frame_cnt_next;
  logic [15:0]      origin_x_next, origin_y_next;
  logic             direction_next, step_next, descend_next;
  logic             invaded_next, cleared_next;

  logic [NUM_COLS-1:0][NUM_ROWS-1:0] by_col;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0] by_row;
  logic [NUM_COLS-1:0] col_occ;
  logic [NUM_ROWS-1:0] row_occ;
  logic [15:0]         lcol, rcol, brow;
  logic [15:0]         left_edge, right_edge, bottom_next;
  logic                cnt_done, tick_hit, hit_right, hit_left, invade_hit, none_alive;

  // Regroup the alive bits by column and by row for occupancy reduction
  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
      assign by_col[c][r] = alive_matrix[r*NUM_COLS+c];
      assign by_row[r][c] = alive_matrix[r*NUM_COLS+c];
    end
    assign row_occ[r] = |by_row[r];
  end
  for (genvar c = 0; c < NUM_COLS; c++) begin : g_occ
    assign col_occ[c] = |by_col[c];
  end

  // Popcount of the live formation
  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_ALIENS; i++) begin
      pop = pop + CNT_W'(alive_matrix[i]);
    end
  end

  // Occupied column/row extents of the formation
  always_comb begin
    lcol = '0;
    rcol = '0;
    brow = '0;
    for (int c = NUM_COLS - 1; c >= 0; c--) begin
      if (col_occ[c]) lcol = 16'(c);
    end
    for (int c = 0; c < NUM_COLS; c++) begin
      if (col_occ[c]) rcol = 16'(c);
    end
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (row_occ[r]) brow = 16'(r);
    end
  end

  assign left_edge   = origin_x + 16'(lcol * ALIEN_SPACING_X);
  assign right_edge  = origin_x + 16'(rcol * ALIEN_SPACING_X) + 16'(ALIEN_WIDTH);
  assign bottom_next = origin_y + 16'(STEP_Y) + 16'(brow * ALIEN_SPACING_Y) + 16'(ALIEN_HEIGHT);

  assign none_alive  = (alive_count == '0);
  assign cnt_done    = ({1'b0, frame_cnt} + 9'd1) >= {1'b0, period};
  assign tick_hit    = frame_tick & enable & cnt_done;
  assign hit_right   = direction  & ((right_edge + 16'(STEP_X)) > 16'(SCREEN_RIGHT));
  assign hit_left    = ~direction & (left_edge < 16'(SCREEN_LEFT + STEP_X));
  assign invade_hit  = bottom_next >= 16'(INVADE_Y);
  assign period_next = 8'(MIN_PERIOD) + 8'(alive_count * PERIOD_PER_ALIEN);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_WAIT;
    else        state <= state_next;
  end

  // Next-state logic; restart overrides everything
  always_comb begin
    state_next = state;
    if (restart) begin
      state_next = S_WAIT;
    end else begin
      case (state)
        S_WAIT: begin
          if (none_alive)    state_next = S_HALT;
          else if (tick_hit) state_next = S_EVAL;
        end
        S_EVAL: begin
          if (none_alive)               state_next = S_HALT;
          else if (hit_right | hit_left) state_next = S_DESCEND;
          else                          state_next = S_MARCH;
        end
        S_MARCH:   state_next = S_WAIT;
        S_DESCEND: state_next = invade_hit ? S_HALT : S_WAIT;
        S_HALT:    state_next = S_HALT;
        default:   state_next = S_WAIT;
      endcase
    end
  end

  // Next values of the registered outputs and frame counter
  always_comb begin
    origin_x_next  = origin_x;
    origin_y_next  = origin_y;
    direction_next = direction;
    frame_cnt_next = frame_cnt;
    invaded_next   = invaded;
    cleared_next   = cleared;
    step_next      = 1'b0;
    descend_next   = 1'b0;
    if (restart) begin
      origin_x_next  = 16'(START_X);
      origin_y_next  = 16'(START_Y);
      direction_next = 1'b1;
      frame_cnt_next = '0;
      invaded_next   = 1'b0;
      cleared_next   = 1'b0;
    end else begin
      case (state)
        S_WAIT: begin
          if (none_alive) begin
            cleared_next = 1'b1;
          end else if (frame_tick && enable) begin
            frame_cnt_next = cnt_done ? 8'd0 : frame_cnt + 8'd1;
          end
        end
        S_EVAL: begin
          if (none_alive) cleared_next = 1'b1;
        end
        S_MARCH: begin
          origin_x_next = direction ? origin_x + 16'(STEP_X) : origin_x - 16'(STEP_X);
          step_next     = 1'b1;
        end
        S_DESCEND: begin
          origin_y_next  = origin_y + 16'(STEP_Y);
          direction_next = ~direction;
          descend_next   = 1'b1;
          if (invade_hit) invaded_next = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers; alive_count resets to a full formation so the
  // popcount latency cannot flag a spurious clear straight out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive_count   <= CNT_W'(NUM_ALIENS);
      period        <= 8'(MIN_PERIOD + NUM_ALIENS * PERIOD_PER_ALIEN);
      frame_cnt     <= '0;
      origin_x      <= 16'(START_X);
      origin_y      <= 16'(START_Y);
      direction     <= 1'b1;
      step_pulse    <= 1'b0;
      descend_pulse <= 1'b0;
      invaded       <= 1'b0;
      cleared       <= 1'b0;
    end else begin
      alive_count   <= pop;
      period        <= period_next;
      frame_cnt     <= frame_cnt_next;
      origin_x      <= origin_x_next;
      origin_y      <= origin_y_next;
      direction     <= direction_next;
      step_pulse    <= step_next;
      descend_pulse <= descend_next;
      invaded       <= invaded_next;
      cleared       <= cleared_next;
    end
  end

endmodule

// File: tb/tb_alien_march_controller.sv
// Directed bench for alien_march_controller; a second instance uses INVADE_Y=160.
module tb_alien_march_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick;
  logic        enable;
  logic        restart;
  logic [14:0] alive_matrix;

  logic [15:0] ox1, oy1, ox2, oy2;
  logic        dir1, dir2, sp1, sp2, dp1, dp2, inv1, inv2, clr1, clr2;
  logic [7:0]  per1, per2;

  int tests = 0;
  int fails = 0;
  int s1, d1, s2, d2;

  alien_march_controller dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .enable(enable),
    .restart(restart), .alive_matrix(alive_matrix),
    .origin_x(ox1), .origin_y(oy1), .direction(dir1), .step_pulse(sp1),
    .descend_pulse(dp1), .period(per1), .invaded(inv1), .cleared(clr1)
  );

  alien_march_controller #(.INVADE_Y(160)) dut_inv (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .enable(enable),
    .restart(restart), .alive_matrix(alive_matrix),
    .origin_x(ox2), .origin_y(oy2), .direction(dir2), .step_pulse(sp2),
    .descend_pulse(dp2), .period(per2), .invaded(inv2), .cleared(clr2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue n frame ticks, 4 cycles apart, counting pulses from both instances
  task automatic do_ticks(input int n);
    s1 = 0; d1 = 0; s2 = 0; d2 = 0;
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        frame_tick = 1'b0;
        s1 += int'(sp1); d1 += int'(dp1);
        s2 += int'(sp2); d2 += int'(dp2);
      end
    end
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_n        = 1'b0;
    frame_tick   = 1'b0;
    enable       = 1'b0;
    restart      = 1'b0;
    alive_matrix = 15'h7fff;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_origin_x", 32'(ox1), 32'd100);
    check("rst_origin_y", 32'(oy1), 32'd50);
    check("rst_direction", 32'(dir1), 32'd1);
    check("rst_pulses", 32'({sp1, dp1}), 32'd0);
    check("rst_flags", 32'({inv1, clr1}), 32'd0);
    rst_n  = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check("full_period", 32'(per1), 32'd32);
    check("no_false_clear", 32'(clr1), 32'd0);

    // Test 1: 32 ticks at full formation give exactly one step
    do_ticks(31);
    check("t1_31_ticks_steps", 32'(s1), 32'd0);
    do_ticks(1);
    check("t1_32nd_tick_steps", 32'(s1), 32'd1);
    check("t1_origin_x", 32'(ox1), 32'd104);
    check("t1_period", 32'(per1), 32'd32);

    // Test 2: lone alien (0,0) -> period 4
    alive_matrix = 15'h0001;
    repeat (3) @(negedge clk);
    check("t2_period", 32'(per1), 32'd4);
    do_ticks(4);
    check("t2_4_ticks_steps", 32'(s1), 32'd1);
    check("t2_origin_x", 32'(ox1), 32'd108);
    do_ticks(3);
    check("t2_3_ticks_steps", 32'(s1), 32'd0);

    // Tests 3 and 5: march right to the edge, descend, march left, descend again
    alive_matrix = 15'h7fff;
    do_restart();
    check("restart_origin_x", 32'(ox1), 32'd100);
    check("restart_period", 32'(per1), 32'd32);
    do_ticks(61 * 32);
    check("t3_steps_right", 32'(s1), 32'd61);
    check("t3_no_descend", 32'(d1), 32'd0);
    check("t3_origin_x_edge", 32'(ox1), 32'd344);
    do_ticks(32);
    check("t3_edge_steps", 32'(s1), 32'd0);
    check("t3_edge_descend", 32'(d1), 32'd1);
    check("t3_origin_y", 32'(oy1), 32'd66);
    check("t3_direction", 32'(dir1), 32'd0);
    check("t3_origin_x_hold", 32'(ox1), 32'd344);
    check("t5_first_no_invade", 32'(inv2), 32'd0);
    check("t5_first_origin_y", 32'(oy2), 32'd66);
    do_ticks(85 * 32);
    check("t3_steps_left", 32'(s1), 32'd84);
    check("t3_left_descend", 32'(d1), 32'd1);
    check("t3_left_origin_x", 32'(ox1), 32'd8);
    check("t3_left_origin_y", 32'(oy1), 32'd82);
    check("t3_left_direction", 32'(dir1), 32'd1);
    check("t3_default_no_invade", 32'(inv1), 32'd0);
    check("t5_origin_y", 32'(oy2), 32'd82);
    check("t5_invaded", 32'(inv2), 32'd1);
    do_ticks(40);
    check("t5_halt_pulses", 32'(s2 + d2), 32'd0);
    check("t5_halt_origin_x", 32'(ox2), 32'd8);
    check("t3_default_keeps_marching", 32'(s1), 32'd1);
    check("t3_default_origin_x", 32'(ox1), 32'd12);

    // Test 4: wave cleared
    do_restart();
    check("t4_restart_invaded", 32'(inv2), 32'd0);
    alive_matrix = 15'h0000;
    repeat (2) @(negedge clk);
    check("t4_cleared", 32'(clr1), 32'd1);
    do_ticks(40);
    check("t4_no_pulses", 32'(s1 + d1), 32'd0);
    check("t4_origin_x", 32'(ox1), 32'd100);
    check("t4_period", 32'(per1), 32'd2);

    // Test 6a: restart on the same cycle as a qualifying tick
    alive_matrix = 15'h7fff;
    do_restart();
    check("t6_cleared_reset", 32'(clr1), 32'd0);
    do_ticks(31);
    frame_tick = 1'b1;
    restart    = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    restart    = 1'b0;
    s1 = 0;
    repeat (3) begin
      @(negedge clk);
      s1 += int'(sp1) + int'(dp1);
    end
    check("t6_restart_no_pulse", 32'(s1), 32'd0);
    check("t6_restart_origin_x", 32'(ox1), 32'd100);
    do_ticks(31);
    check("t6_cnt_cleared", 32'(s1), 32'd0);
    do_ticks(1);
    check("t6_step_after", 32'(s1), 32'd1);
    check("t6_origin_x_after", 32'(ox1), 32'd104);

    // Test 6b: rst_n asserted while in EVAL
    do_ticks(31);
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    rst_n      = 1'b0;
    #1;
    check("t6_rst_origin_x", 32'(ox1), 32'd100);
    check("t6_rst_origin_y", 32'(oy1), 32'd50);
    s1 = 0;
    repeat (2) begin
      @(negedge clk);
      s1 += int'(sp1);
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      s1 += int'(sp1);
    end
    check("t6_rst_no_step", 32'(s1), 32'd0);
    check("t6_rst_origin_x_hold", 32'(ox1), 32'd100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
